// File: rtl/atari_bus_master.sv
// Atari 8-bit cartridge-port bus initiator: free-running phi2 generator plus
// single S4/S5/CCTL/idle read and write cycles queued one at a time by the host.
module atari_bus_master #(
  parameter int PHI2_LO    = 14,
  parameter int PHI2_HI    = 14,
  parameter int ADDR_SETUP = 4,
  parameter int SAMPLE_OFF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_region,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        open_bus,
  output logic        phi2,
  output logic [12:0] cart_a,
  inout  wire  [7:0]  cart_d,
  output logic        s4_n,
  output logic        s5_n,
  output logic        cctl_n,
  output logic        r_w,
  input  logic        rd4,
  input  logic        rd5
);

  localparam int P  = PHI2_LO + PHI2_HI;
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] CNT_LAST    = CW'(P - 1);
  localparam logic [CW-1:0] CNT_HI      = CW'(PHI2_LO);
  localparam logic [CW-1:0] CNT_LO_LAST = CW'(PHI2_LO - 1);
  localparam logic [CW-1:0] CNT_SETUP   = CW'(ADDR_SETUP);
  localparam logic [CW-1:0] CNT_SAMPLE  = CW'(P - 1 - SAMPLE_OFF);

  localparam logic [1:0] REGION_S4   = 2'd0;
  localparam logic [1:0] REGION_S5   = 2'd1;
  localparam logic [1:0] REGION_CCTL = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_END  = 3'd4
  } state_t;

  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic          wrap_s, accept_s, busy_nx_s;
  logic          we_r, drive_r;
  logic [1:0]    region_r;
  logic [12:0]   addr_r;
  logic [7:0]    wdata_r;

  // Active-low select pattern {cctl_n, s5_n, s4_n}; the idle region selects nothing.
  function automatic logic [2:0] select_decode(input logic [1:0] region);
    case (region)
      REGION_S4:   select_decode = 3'b110;
      REGION_S5:   select_decode = 3'b101;
      REGION_CCTL: select_decode = 3'b011;
      default:     select_decode = 3'b111;
    endcase
  endfunction

  assign cart_d = drive_r ? wdata_r : 8'hzz;

  // Phase counter successor and request acceptance qualifier.
  always_comb begin
    wrap_s   = (cnt_r == CNT_LAST);
    accept_s = req && !busy;
    if (wrap_s) begin
      cnt_nx_s = {CW{1'b0}};
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  // Free-running phase counter and registered phi2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      phi2  <= 1'b0;
    end else begin
      cnt_r <= cnt_nx_s;
      phi2  <= (cnt_nx_s >= CNT_HI);
    end
  end

  // Bus-cycle state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bus-cycle next state: cycles always start on a period boundary.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_PEND;
        else          state_nx_s = ST_IDLE;
      end
      ST_PEND: begin
        if (wrap_s) state_nx_s = ST_ADDR;
        else        state_nx_s = ST_PEND;
      end
      ST_ADDR: begin
        if (cnt_r == CNT_LO_LAST) state_nx_s = ST_DATA;
        else                      state_nx_s = ST_ADDR;
      end
      ST_DATA: begin
        if (wrap_s) state_nx_s = ST_END;
        else        state_nx_s = ST_DATA;
      end
      ST_END: begin
        if (accept_s) state_nx_s = ST_PEND;
        else          state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
    busy_nx_s = (state_nx_s == ST_PEND) || (state_nx_s == ST_ADDR) || (state_nx_s == ST_DATA);
  end

  // Pending request slot, loaded only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r     <= 1'b0;
      region_r <= 2'd0;
      addr_r   <= 13'd0;
      wdata_r  <= 8'd0;
    end else if (accept_s) begin
      we_r     <= req_we;
      region_r <= req_region;
      addr_r   <= req_addr;
      wdata_r  <= req_wdata;
    end
  end

  // Host handshake: busy level and end-of-cycle ack pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      ack  <= 1'b0;
    end else begin
      busy <= busy_nx_s;
      ack  <= (state_nx_s == ST_END);
    end
  end

  // Address, direction and selects; cart_a is deliberately left holding after END.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cart_a                 <= 13'd0;
      r_w                    <= 1'b1;
      {cctl_n, s5_n, s4_n}   <= 3'b111;
    end else begin
      if (state_r == ST_PEND && wrap_s) begin
        cart_a <= addr_r;
        r_w    <= ~we_r;
      end else if (state_nx_s == ST_END) begin
        r_w    <= 1'b1;
      end
      if (state_nx_s == ST_ADDR && cnt_nx_s == CNT_SETUP) begin
        {cctl_n, s5_n, s4_n} <= select_decode(region_r);
      end else if (state_nx_s == ST_END) begin
        {cctl_n, s5_n, s4_n} <= 3'b111;
      end
    end
  end

  // Write data is held one clk past the falling edge of phi2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_r <= 1'b0;
    end else begin
      drive_r <= we_r && ((state_nx_s == ST_DATA) || (state_nx_s == ST_END));
    end
  end

  // Read capture a few clks before phi2 falls, with ROM-present check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata    <= 8'd0;
      open_bus <= 1'b0;
    end else if (state_r == ST_DATA && cnt_r == CNT_SAMPLE) begin
      if (!we_r) begin
        rdata <= cart_d;
      end
      open_bus <= !we_r && (((region_r == REGION_S4) && !rd4) || ((region_r == REGION_S5) && !rd5));
    end
  end

endmodule

// File: tb/tb_atari_bus_master.sv
// Directed bench for atari_bus_master: a period/offset timeline model checked
// every cycle, plus hand-computed expectations for the headline scenarios.
module tb_atari_bus_master;

  localparam int P     = 28;
  localparam int LO    = 14;
  localparam int SETUP = 4;
  localparam int SOFF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_region = 2'd0;
  logic [12:0] req_addr = 13'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        rd4 = 1'b1;
  logic        rd5 = 1'b1;
  logic        busy, ack, open_bus, phi2, s4_n, s5_n, cctl_n, r_w;
  logic [7:0]  rdata;
  logic [12:0] cart_a;
  wire  [7:0]  cart_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Cartridge ROM contents seen by the bench.
  function automatic logic [7:0] rom(input logic [12:0] a);
    if (a == 13'h0123) return 8'hA5;
    else               return a[7:0] ^ 8'h3C;
  endfunction

  // Cartridge drives only when selected, reading, and its ROM is present.
  assign cart_d = (r_w && ((!s4_n && rd4) || (!s5_n && rd5))) ? rom(cart_a) : 8'hzz;
  pullup (cart_d);

  atari_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_region(req_region),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .ack(ack), .rdata(rdata),
    .open_bus(open_bus), .phi2(phi2), .cart_a(cart_a), .cart_d(cart_d), .s4_n(s4_n),
    .s5_n(s5_n), .cctl_n(cctl_n), .r_w(r_w), .rd4(rd4), .rd5(rd5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          mcnt, m_k, cyc, last_rise;
  bit          m_act;
  logic        m_we, m_ob, prev_phi2;
  logic [1:0]  m_reg;
  logic [12:0] m_addr, m_cart_a;
  logic [7:0]  m_wd, m_rdata;

  function automatic logic [7:0] bus_read(input logic [1:0] r, input logic [12:0] a);
    if ((r == 2'd0 && rd4) || (r == 2'd1 && rd5)) return rom(a);
    else                                          return 8'hFF;
  endfunction

  task automatic model_reset();
    mcnt = 0; m_act = 1'b0; m_k = -1;
    m_cart_a = 13'd0; m_rdata = 8'd0; m_ob = 1'b0;
    last_rise = -1; prev_phi2 = 1'b0;
  endtask

  // m_k is the clk offset from the start of the bus period that carries the cycle.
  task automatic model_step();
    bit busy_pre;
    if (rst) begin
      model_reset();
    end else begin
      busy_pre = m_act && (m_k < P);
      mcnt = (mcnt + 1) % P;
      if (m_act) begin
        if (m_k >= 0)       m_k++;
        else if (mcnt == 0) m_k = 0;
        if (m_k == 0) m_cart_a = m_addr;
        if (m_k == P - SOFF) begin
          if (!m_we) m_rdata = bus_read(m_reg, m_addr);
          m_ob = !m_we && ((m_reg == 2'd0 && !rd4) || (m_reg == 2'd1 && !rd5));
        end
        if (m_k > P) m_act = 1'b0;
      end
      if (req && !busy_pre) begin
        m_act = 1'b1; m_k = -1;
        m_we = req_we; m_reg = req_region; m_addr = req_addr; m_wd = req_wdata;
      end
    end
  endtask

  task automatic compare();
    logic sel_on, exp_rw, exp_drv, exp_ack;
    logic [7:0] exp_d;
    if (rst) model_reset();
    sel_on  = m_act && m_k >= SETUP && m_k <= P - 1;
    exp_rw  = !(m_act && m_k >= 0 && m_k <= P - 1 && m_we);
    exp_drv = m_act && m_we && m_k >= LO && m_k <= P;
    exp_ack = m_act && m_k == P;
    exp_d   = exp_drv ? m_wd : ((exp_rw && sel_on) ? bus_read(m_reg, m_addr) : 8'hFF);
    chk("phi2",   32'(phi2),   32'(mcnt >= LO));
    chk("busy",   32'(busy),   32'(m_act && m_k < P));
    chk("ack",    32'(ack),    32'(exp_ack));
    chk("s4_n",   32'(s4_n),   32'(!(sel_on && m_reg == 2'd0)));
    chk("s5_n",   32'(s5_n),   32'(!(sel_on && m_reg == 2'd1)));
    chk("cctl_n", 32'(cctl_n), 32'(!(sel_on && m_reg == 2'd2)));
    chk("r_w",    32'(r_w),    32'(exp_rw));
    chk("cart_a", 32'(cart_a), 32'(m_cart_a));
    chk("cart_d", 32'(cart_d), 32'(exp_d));
    chk("rdata",  32'(rdata),  32'(m_rdata));
    if (exp_ack || rst) chk("open_bus", 32'(open_bus), 32'(m_ob));
    cyc++;
    if (phi2 && !prev_phi2) begin
      if (last_rise >= 0) chk("phi2_period", cyc - last_rise, P);
      last_rise = cyc;
    end
    prev_phi2 = phi2;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk); model_step();
      @(negedge clk); compare();
    end
  end

  // ---------------- event counters ----------------
  int s4_lo = 0, s5_lo = 0, cc_lo = 0, ack_n = 0, d00_n = 0;
  always @(negedge clk) begin
    if (!s4_n)           s4_lo <= s4_lo + 1;
    if (!s5_n)           s5_lo <= s5_lo + 1;
    if (!cctl_n)         cc_lo <= cc_lo + 1;
    if (ack)             ack_n <= ack_n + 1;
    if (cart_d == 8'h00) d00_n <= d00_n + 1;
  end

  int b4, b5, bc, ba, bd;
  task automatic snap();
    b4 = s4_lo; b5 = s5_lo; bc = cc_lo; ba = ack_n; bd = d00_n;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (mcnt != target && n < 2 * P) begin step(); n++; end
    if (mcnt != target) begin
      n_vec++; n_err++;
      $display("FAIL wait_cnt: got %0d, expected %0d", mcnt, target);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] region, input logic [12:0] addr,
                       input logic [7:0] wd, input int target);
    wait_cnt(target);
    req = 1'b1; req_we = we; req_region = region; req_addr = addr; req_wdata = wd;
  endtask

  task automatic wait_ack(output int lat);
    int n = 0;
    do begin step(); n++; end while (!ack && n <= 3 * P);
    if (!ack) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ack, expected ack within %0d clk", 3 * P);
    end
    lat = n - 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish by 400000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, n;
    repeat (3) @(negedge clk);
    chk("rst_phi2",   32'(phi2),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_ack",    32'(ack),    32'd0);
    chk("rst_sel",    32'({cctl_n, s5_n, s4_n}), 32'd7);
    chk("rst_r_w",    32'(r_w),    32'd1);
    chk("rst_cart_a", 32'(cart_a), 32'd0);
    chk("rst_cart_d", 32'(cart_d), 32'hFF);
    chk("rst_rdata",  32'(rdata),  32'd0);
    chk("rst_open",   32'(open_bus), 32'd0);
    rst = 1'b0;

    // S5 read of a present ROM
    snap();
    issue(1'b0, 2'd1, 13'h0123, 8'h00, 5);
    wait_ack(lat);
    chk("s5rd_rdata", 32'(rdata), 32'hA5);
    chk("s5rd_open",  32'(open_bus), 32'd0);
    step();
    chk("s5rd_s5_low", s5_lo - b5, 24);
    chk("s5rd_other_low", (s4_lo - b4) + (cc_lo - bc), 0);
    chk("s5rd_acks", ack_n - ba, 1);

    // CCTL write of 8'h00
    snap();
    issue(1'b1, 2'd2, 13'h00E8, 8'h00, 10);
    wait_ack(lat);
    step();
    chk("cctl_low", cc_lo - bc, 24);
    chk("cctl_s45_low", (s4_lo - b4) + (s5_lo - b5), 0);
    chk("cctl_d_drive", d00_n - bd, 15);

    // S4 read with no ROM: pulled-up open bus
    rd4 = 1'b0;
    issue(1'b0, 2'd0, 13'h0456, 8'h00, 20);
    wait_ack(lat);
    chk("s4ob_rdata", 32'(rdata), 32'hFF);
    chk("s4ob_open",  32'(open_bus), 32'd1);
    step();
    rd4 = 1'b1;

    // req pulses while busy are ignored
    snap();
    issue(1'b0, 2'd1, 13'h0ABC, 8'h00, 3);
    step();
    repeat (3) begin
      req = 1'b1; req_we = 1'b1; req_region = 2'd0; req_addr = 13'h1111;
      step(); step();
    end
    wait_ack(lat);
    chk("busyreq_rdata", 32'(rdata), 32'h80);
    step();
    chk("busyreq_acks", ack_n - ba, 1);
    chk("busyreq_s5_low", s5_lo - b5, 24);
    chk("busyreq_s4_low", s4_lo - b4, 0);

    // Accept latency extremes and an accept during END
    issue(1'b0, 2'd0, 13'h0200, 8'h00, P - 1);
    wait_ack(lat);
    chk("lat_cnt0", lat, 56);
    issue(1'b0, 2'd0, 13'h0201, 8'h00, P - 2);
    wait_ack(lat);
    chk("lat_cnt27", lat, 29);
    issue(1'b1, 2'd1, 13'h0202, 8'h3C, 0);
    wait_ack(lat);
    chk("lat_in_end", lat, 55);

    // Reset in the DATA phase of a write
    issue(1'b1, 2'd0, 13'h1FFF, 8'h5A, 8);
    n = 0;
    while (!(m_act && m_k == 20) && n < 3 * P) begin step(); n++; end
    chk("midrst_reach_data", 32'(m_act && m_k == 20), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cart_d", 32'(cart_d), 32'hFF);
    chk("midrst_sel",    32'({cctl_n, s5_n, s4_n}), 32'd7);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_ack",    32'(ack),  32'd0);
    chk("midrst_r_w",    32'(r_w),  32'd1);
    snap();
    step();
    step();
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (!phi2 && n < 2 * P);
    chk("midrst_phi2_rise", n, LO);
    repeat (2 * P) step();
    chk("midrst_no_ack", ack_n - ba, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/atari_bus_master.md
# atari_bus_master

Atari 8-bit cartridge-port bus initiator for the cartridge bench and dumper fixture. It generates the free-running `phi2` clock and issues single read/write cycles on the cartridge slot. Supported cycle types are `$8000` (S4), `$A000` (S5), `$D5xx` (CCTL) and idle. Host logic queues one request at a time and receives read data with an ack pulse.

## Interface
- `PHI2_LO` (default 14): clk cycles per phi2 low phase; must be ≥ `ADDR_SETUP`+1.
- `PHI2_HI` (default 14): clk cycles per phi2 high phase; must be ≥ `SAMPLE_OFF`+2.
- `ADDR_SETUP` (default 4): clk cycles from start of low phase to strobe assertion.
- `SAMPLE_OFF` (default 2): read-data capture point, in clk cycles before phi2 falls.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; accepted when `busy`=0.
- `req_we`  in  1  1 = write cycle, 0 = read cycle.
- `req_region`  in  2  0 = S4, 1 = S5, 2 = CCTL, 3 = idle cycle (no strobe).
- `req_addr`  in  13  value for `cart_a`.
- `req_wdata`  in  8  write data.
- `busy`  out  1  request pending or in progress.
- `ack`  out  1  one-clk pulse at cycle end.
- `rdata`  out  8  captured read data; valid with `ack`, held until the next capture.
- `open_bus`  out  1  valid with `ack`: read to S4/S5 while the matching `rd4`/`rd5` was 0 at the capture point.
- `phi2`  out  1  generated bus clock.
- `cart_a`  out  13  address.
- `cart_d`  inout  8  data; driven only during the write data window.
- `s4_n`, `s5_n`, `cctl_n`  out  1 each  active-low selects.
- `r_w`  out  1  1 = read.
- `rd4`, `rd5`  in  1 each  cartridge ROM-present lines.

## Operation
- Phase counter `cnt` runs 0..P-1 with P = `PHI2_LO`+`PHI2_HI`, wrapping continuously, never paused by requests.
- `phi2` = 1 when `cnt` ≥ `PHI2_LO`. It is registered and glitch-free.
- A request is accepted when `req`=1 and `busy`=0.
  - Accepted fields are latched into a pending slot and `busy` goes to 1.
  - `req` while `busy`=1 is ignored. No queue, no error.
- States:
  - IDLE → PEND on accept.
  - PEND → ADDR on the edge where `cnt` wraps P-1→0.
  - ADDR (low phase) → DATA when `cnt` reaches `PHI2_LO`.
  - DATA (high phase) → END on the wrap.
  - END lasts one clk, then → IDLE.
- Entering ADDR:
  - `cart_a` ← addr.
  - `r_w` ← ~we.
  - All selects remain 1.
- At `cnt`=`ADDR_SETUP`, the select for the region asserts: S4→`s4_n`=0, S5→`s5_n`=0, CCTL→`cctl_n`=0, idle→none. Exactly one select is low at a time.
- Write: `cart_d` is driven with wdata from `cnt`=`PHI2_LO` through the END clk inclusive (one-clk hold after phi2 falls). It is hi-Z at all other times.
- Read: `rdata` ← `cart_d` on the edge ending `cnt` = P-1-`SAMPLE_OFF`. `rd4`/`rd5` are sampled at the same edge to form `open_bus`. `open_bus` is 0 for writes, CCTL and idle.
- END (`cnt`=0 of the next period):
  - `ack`=1 and `busy`=0.
  - All selects = 1, `r_w` = 1.
  - `cart_a` holds its value.
  - A new request accepted in the END clk waits for the following wrap, giving one idle bus period between cycles.

## Timing
- Reset values:
  - `phi2`=0, `cnt`=0.
  - `s4_n`=`s5_n`=`cctl_n`=1, `r_w`=1.
  - `cart_a`=0, `cart_d`=Z.
  - `busy`=0, `ack`=0, `rdata`=0, `open_bus`=0.
  - State IDLE.
- Reset asserted mid-cycle: all outputs return to reset values asynchronously. No `ack` is issued and the pending request is dropped.
- Latency from accept to `ack`: (P - `cnt`_at_accept) + P clk, between P+1 and 2P clk.
- Selects are low for P-`ADDR_SETUP` clk per cycle.
- Default `phi2` period is 28 clk.

## Test plan
- S5 read: `rd5`=1, bench cart returns 8'hA5 at addr 13'h0123 → `s5_n` low for 24 clk, `r_w`=1, `ack` with `rdata`=8'hA5, `open_bus`=0.
- CCTL write `req_addr`=13'h00E8, wdata 8'h00 → `cctl_n` low, `r_w`=0, `cart_d`=8'h00 during phi2 high plus 1 clk, then Z. `s4_n`/`s5_n` stay 1.
- S4 read with `rd4`=0: bus pull-up model gives 8'hFF → `rdata`=8'hFF, `open_bus`=1.
- `req` pulsed while `busy`=1 → ignored: exactly one `ack` and one select assertion.
- Accept at `cnt`=0 and at `cnt`=27 → `ack` after 56 and 29 clk respectively. `phi2` period stays 28 clk throughout.
- `rst` asserted during the DATA phase of a write → `cart_d`=Z and selects=1 immediately. No `ack`, `busy`=0, `cnt` restarts at 0.
